// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Callers zero-extend narrower characters to 9 bits.
  function automatic logic parity_calc(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver line and PIO-side result register bundle.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 busy;

  modport master (
    input  rx, out_ready, clr_overrun,
    output data_out, out_valid, parity_err, frame_err, break_det, overrun, busy
  );

  modport slave (
    output rx, out_ready, clr_overrun,
    input  data_out, out_valid, parity_err, frame_err, break_det, overrun, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw line plus a 3-sample majority vote.
module uart_rx_sync (
  input  logic clk16x,
  input  logic reset,
  input  logic rx,
  output logic s2,
  output logic vote
);
  logic       s1;
  logic [2:0] hist;

  always_ff @(posedge clk16x or posedge reset) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= '1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      hist <= {hist[1:0], s2};
    end
  end

  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
endmodule

// File: rtl/uart_rx_param.sv
// Oversampling serial receiver: start validation, voted mid-bit sampling,
// optional parity, 1/2 stop bits and a valid/ready result register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk16x,
  input  logic            reset,
  uart_rx_param_if.master bus
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 s2;
  logic                 vote;
  logic                 frame_bad;
  logic                 bit_end;

  uart_rx_sync u_sync (
    .clk16x (clk16x),
    .reset  (reset),
    .rx     (bus.rx),
    .s2     (s2),
    .vote   (vote)
  );

  assign bit_end   = (cnt == CNT_W'(OVERSAMPLE - 1));
  assign frame_bad = ferr | ~vote;
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk16x or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shreg          <= '0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      bus.data_out   <= '0;
      bus.out_valid  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.break_det  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      // Consume and clear come first so a commit later in this block wins.
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (bus.clr_overrun) bus.overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (!s2) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_W'(OVERSAMPLE / 2 - 1)) begin
            cnt <= '0;
            if (vote) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
              perr    <= 1'b0;
              ferr    <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              state    <= (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (bit_end) begin
            cnt      <= '0;
            perr     <= (parity_calc(9'(shreg)) ^ vote) != (PARITY == PAR_ODD);
            stop_idx <= 1'b0;
            state    <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              if (!bus.out_valid || bus.out_ready) begin
                bus.data_out   <= shreg;
                bus.parity_err <= perr;
                bus.frame_err  <= frame_bad;
                bus.break_det  <= frame_bad && (shreg == '0);
                bus.out_valid  <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
              ferr  <= frame_bad;
              state <= frame_bad ? WAIT_HIGH : IDLE;
            end else begin
              ferr     <= frame_bad;
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1 and 8E1 instances on one clock.
module tb_uart_rx_param;
  logic clk;
  logic reset;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  uart_rx_param_if #(.DATA_BITS(8)) if_n ();
  uart_rx_param_if #(.DATA_BITS(8)) if_e ();

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk16x (clk),
    .reset  (reset),
    .bus    (if_n)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut_e (
    .clk16x (clk),
    .reset  (reset),
    .bus    (if_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bit(input int sel, input logic b, input int cycles);
    if (sel == 0) if_n.rx = b;
    else          if_e.rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nd,
                            input bit has_par, input logic pbit, input logic stopv);
    drive_bit(sel, 1'b0, 16);
    for (int i = 0; i < nd; i++) drive_bit(sel, d[i], 16);
    if (has_par) drive_bit(sel, pbit, 16);
    drive_bit(sel, stopv, 16);
    drive_bit(sel, 1'b1, 0);
  endtask

  task automatic wait_valid(input int sel, input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if ((sel == 0 && if_n.out_valid === 1'b1) || (sel == 1 && if_e.out_valid === 1'b1)) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume(input int sel);
    if (sel == 0) if_n.out_ready = 1'b1;
    else          if_e.out_ready = 1'b1;
    @(negedge clk);
    if_n.out_ready = 1'b0;
    if_e.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_n.rx = 1'b1; if_e.rx = 1'b1;
    if_n.out_ready = 1'b0; if_e.out_ready = 1'b0;
    if_n.clr_overrun = 1'b0; if_e.clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({if_n.out_valid, if_n.parity_err, if_n.frame_err, if_n.break_det, if_n.overrun} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {if_n.out_valid, if_n.parity_err, if_n.frame_err, if_n.break_det, if_n.overrun});
    end
    vectors++;
    if (if_n.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h, expected 00", if_n.data_out);
    end
    vectors++;
    if (if_n.busy !== 1'b0 || if_e.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b%b, expected 00", if_n.busy, if_e.busy);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency_8n1;
    exp_t e;
    sb.push_back('{data: 8'h41, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 9'h041, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(negedge clk);
        vectors++;
        if (if_n.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL latency_early: out_valid=%b before edge 154, expected 0", if_n.out_valid);
        end
        @(negedge clk);
        vectors++;
        if (if_n.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL latency_edge154: out_valid=%b, expected 1", if_n.out_valid);
        end
        @(negedge clk);
        vectors++;
        if (if_n.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL latency_busy: busy=%b at edge 155, expected 0", if_n.busy);
        end
      end
    join
    e = sb.pop_front();
    vectors++;
    if (if_n.data_out !== e.data || {if_n.parity_err, if_n.frame_err, if_n.break_det} !== {e.perr, e.ferr, e.brk}) begin
      miscompares++;
      $display("FAIL latency_data: got %h/%b%b%b, expected %h/%b%b%b", if_n.data_out,
               if_n.parity_err, if_n.frame_err, if_n.break_det, e.data, e.perr, e.ferr, e.brk);
    end
    consume(0);
    vectors++;
    if (if_n.out_valid !== 1'b0 || if_n.data_out !== 8'h41) begin
      miscompares++;
      $display("FAIL consume_hold: valid=%b data=%h, expected 0/41", if_n.out_valid, if_n.data_out);
    end
  endtask

  task automatic test_parity;
    exp_t e;
    bit   seen;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{data: 8'h55, perr: (k == 0), ferr: 1'b0, brk: 1'b0});
      send_frame(1, 9'h055, 8, 1'b1, (k == 0), 1'b1);
      wait_valid(1, 40, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("FAIL parity_timeout_%0d: out_valid=0, expected 1", k);
      end
      vectors++;
      if (if_e.data_out !== e.data || if_e.parity_err !== e.perr || if_e.frame_err !== e.ferr) begin
        miscompares++;
        $display("FAIL parity_%0d: got %h perr=%b ferr=%b, expected %h perr=%b ferr=%b", k,
                 if_e.data_out, if_e.parity_err, if_e.frame_err, e.data, e.perr, e.ferr);
      end
      consume(1);
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_false_start;
    int waited;
    drive_bit(0, 1'b0, 4);
    vectors++;
    if (if_n.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL false_start_busy_rise: busy=%b, expected 1", if_n.busy);
    end
    drive_bit(0, 1'b1, 0);
    waited = 0;
    while (if_n.busy === 1'b1 && waited < 11) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (if_n.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start_busy_fall: busy=%b after %0d cycles, expected 0", if_n.busy, waited);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (if_n.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start_valid: out_valid=%b, expected 0", if_n.out_valid);
    end
  endtask

  task automatic test_break;
    exp_t e;
    bit   seen;
    sb.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    drive_bit(0, 1'b0, 40 * 16);
    e = sb.pop_front();
    vectors++;
    if (if_n.out_valid !== 1'b1 || if_n.overrun !== 1'b0 || if_n.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL break_state: valid=%b overrun=%b busy=%b, expected 1/0/1",
               if_n.out_valid, if_n.overrun, if_n.busy);
    end
    vectors++;
    if (if_n.data_out !== e.data || if_n.frame_err !== e.ferr || if_n.break_det !== e.brk) begin
      miscompares++;
      $display("FAIL break_flags: got %h ferr=%b brk=%b, expected %h ferr=%b brk=%b",
               if_n.data_out, if_n.frame_err, if_n.break_det, e.data, e.ferr, e.brk);
    end
    drive_bit(0, 1'b1, 32);
    vectors++;
    if (if_n.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_release: busy=%b, expected 0", if_n.busy);
    end
    consume(0);
    sb.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 40, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || if_n.data_out !== e.data || if_n.frame_err !== e.ferr || if_n.break_det !== e.brk) begin
      miscompares++;
      $display("FAIL break_next_frame: valid=%b data=%h ferr=%b brk=%b, expected 1 %h %b %b",
               seen, if_n.data_out, if_n.frame_err, if_n.break_det, e.data, e.ferr, e.brk);
    end
    consume(0);
  endtask

  task automatic test_overrun;
    exp_t e;
    sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (if_n.out_valid !== 1'b1 || if_n.data_out !== e.data || if_n.overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: valid=%b data=%h overrun=%b, expected 1 %h 1",
               if_n.out_valid, if_n.data_out, if_n.overrun, e.data);
    end
    if_n.clr_overrun = 1'b1;
    @(negedge clk);
    if_n.clr_overrun = 1'b0;
    vectors++;
    if (if_n.overrun !== 1'b0 || if_n.out_valid !== 1'b1 || if_n.data_out !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_clear: overrun=%b valid=%b data=%h, expected 0 1 11",
               if_n.overrun, if_n.out_valid, if_n.data_out);
    end
    sb.push_back('{data: 8'h33, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    fork
      send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(negedge clk);
        if_n.out_ready = 1'b1;
        @(negedge clk);
        if_n.out_ready = 1'b0;
      end
    join
    e = sb.pop_front();
    vectors++;
    if (if_n.out_valid !== 1'b1 || if_n.data_out !== e.data || if_n.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_accept: valid=%b data=%h overrun=%b, expected 1 %h 0",
               if_n.out_valid, if_n.data_out, if_n.overrun, e.data);
    end
  endtask

  task automatic test_reset_midframe;
    exp_t       e;
    bit         seen;
    logic [7:0] d;
    d = 8'h3C;
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i], 16);
    drive_bit(0, d[4], 8);
    vectors++;
    if (if_n.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy: busy=%b, expected 1", if_n.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (if_n.busy !== 1'b0 || if_n.out_valid !== 1'b0 || if_n.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midframe_reset: busy=%b valid=%b data=%h, expected 0 0 00",
               if_n.busy, if_n.out_valid, if_n.data_out);
    end
    if_n.rx = 1'b1;
    reset = 1'b0;
    sb.delete();
    sb.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 40, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || if_n.data_out !== e.data || if_n.frame_err !== e.ferr) begin
      miscompares++;
      $display("FAIL after_reset_frame: valid=%b data=%h ferr=%b, expected 1 %h %b",
               seen, if_n.data_out, if_n.frame_err, e.data, e.ferr);
    end
    consume(0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency_8n1();
    test_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
